// File: rtl/arbitro_somador_if.sv
// Bundle of requester, operand and response-channel signals for arbitro_somador.
// master = operand sources / sum consumer side, slave = the arbiter itself.
interface arbitro_somador_if #(parameter int WIDTH = 4);
  logic             req0;
  logic [WIDTH-1:0] op0;
  logic             req1;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] acc_a;
  logic             gnt0;
  logic             gnt1;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_carry;
  logic             busy;

  modport master (
    output req0, op0, req1, op1, acc_a, resp_ready,
    input  gnt0, gnt1, resp_valid, resp_id, resp_data, resp_carry, busy
  );

  modport slave (
    input  req0, op0, req1, op1, acc_a, resp_ready,
    output gnt0, gnt1, resp_valid, resp_id, resp_data, resp_carry, busy
  );
endinterface

// File: rtl/arbitro_somador.sv
// Round-robin arbiter sharing one mux+adder between two requesters, with a
// valid/ready tagged response. Define SOMA_SATURADA_EN to saturate on carry.
module arbitro_somador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  arbitro_somador_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_r;
  logic             prio_r;
  logic             sel_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] op0_r;
  logic [WIDTH-1:0] op1_r;
  logic             resp_valid_r;
  logic             resp_id_r;
  logic [WIDTH-1:0] resp_data_r;
  logic             resp_carry_r;
  logic             busy_r;

  logic             gnt0_s;
  logic             gnt1_s;
  logic [WIDTH-1:0] mux_s;
  logic [WIDTH:0]   sum_s;

  // Map the raw (WIDTH+1)-bit sum to the returned data word.
  function automatic logic [WIDTH-1:0] fold_sum(input logic [WIDTH:0] s);
`ifdef SOMA_SATURADA_EN
    if (s[WIDTH]) begin
      fold_sum = {WIDTH{1'b1}};
    end else begin
      fold_sum = s[WIDTH-1:0];
    end
`else
    fold_sum = s[WIDTH-1:0];
`endif
  endfunction

  // Grant decode: only in IDLE and out of reset; prio breaks ties.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst_n && (state_r == IDLE)) begin
      if (bus.req0 && bus.req1) begin
        if (prio_r) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else begin
        gnt0_s = bus.req0;
        gnt1_s = bus.req1;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Shared datapath: operand mux by captured select, then widened add.
  always_comb begin
    if (sel_r) begin
      mux_s = op1_r;
    end else begin
      mux_s = op0_r;
    end
    sum_s = {1'b0, acc_r} + {1'b0, mux_s};
  end

  // Sequencer FSM with all response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      prio_r       <= 1'b0;
      sel_r        <= 1'b0;
      acc_r        <= {WIDTH{1'b0}};
      op0_r        <= {WIDTH{1'b0}};
      op1_r        <= {WIDTH{1'b0}};
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_data_r  <= {WIDTH{1'b0}};
      resp_carry_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt0_s || gnt1_s) begin
            acc_r   <= bus.acc_a;
            sel_r   <= gnt1_s;
            // Loser of this grant gets priority next time.
            prio_r  <= gnt0_s;
            if (gnt1_s) begin
              op1_r <= bus.op1;
            end else begin
              op0_r <= bus.op0;
            end
            state_r <= EXEC;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        EXEC: begin
          resp_data_r  <= fold_sum(sum_s);
          resp_carry_r <= sum_s[WIDTH];
          resp_id_r    <= sel_r;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
          busy_r       <= 1'b1;
        end
        RESP: begin
          if (resp_valid_r && bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= IDLE;
            busy_r       <= 1'b0;
          end else begin
            state_r      <= RESP;
            busy_r       <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0       = gnt0_s;
  assign bus.gnt1       = gnt1_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_carry = resp_carry_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_arbitro_somador.sv
// Directed self-checking bench for arbitro_somador.
module tb_arbitro_somador;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

`ifdef SOMA_SATURADA_EN
  localparam logic [3:0] OVF_DATA = 4'd15;
`else
  localparam logic [3:0] OVF_DATA = 4'd1;
`endif

  arbitro_somador_if #(.WIDTH(4)) bus ();

  arbitro_somador #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt0"},  {7'd0, bus.gnt0},       8'd0);
    chk({tag, "_gnt1"},  {7'd0, bus.gnt1},       8'd0);
    chk({tag, "_valid"}, {7'd0, bus.resp_valid}, 8'd0);
    chk({tag, "_id"},    {7'd0, bus.resp_id},    8'd0);
    chk({tag, "_data"},  {4'd0, bus.resp_data},  8'd0);
    chk({tag, "_carry"}, {7'd0, bus.resp_carry}, 8'd0);
    chk({tag, "_busy"},  {7'd0, bus.busy},       8'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.op0 = 4'd0;
    bus.op1 = 4'd0;
    bus.acc_a = 4'd0;
    bus.resp_ready = 1'b0;

    // Reset state, with a request present that must not be granted.
    tick();
    bus.req0 = 1'b1;
    tick();
    check_reset_outputs("rst");
    bus.req0 = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single request: 3 + 4 = 7.
    bus.acc_a = 4'd3;
    bus.op0 = 4'd4;
    bus.req0 = 1'b1;
    #1;
    chk("single_gnt0", {7'd0, bus.gnt0}, 8'd1);
    chk("single_gnt1", {7'd0, bus.gnt1}, 8'd0);
    chk("single_busy_idle", {7'd0, bus.busy}, 8'd0);
    tick();
    bus.req0 = 1'b0;
    chk("single_exec_gnt0", {7'd0, bus.gnt0}, 8'd0);
    chk("single_exec_busy", {7'd0, bus.busy}, 8'd1);
    chk("single_exec_valid", {7'd0, bus.resp_valid}, 8'd0);
    tick();
    chk("single_valid", {7'd0, bus.resp_valid}, 8'd1);
    chk("single_id", {7'd0, bus.resp_id}, 8'd0);
    chk("single_data", {4'd0, bus.resp_data}, 8'd7);
    chk("single_carry", {7'd0, bus.resp_carry}, 8'd0);
    bus.resp_ready = 1'b1;
    tick();
    chk("single_done_valid", {7'd0, bus.resp_valid}, 8'd0);
    chk("single_done_busy", {7'd0, bus.busy}, 8'd0);

    // Reset again so prio starts at 0 for contention.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.op0 = 4'd1;
    bus.op1 = 4'd2;
    bus.acc_a = 4'd0;
    bus.resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cont%0d_gnt0", k), {7'd0, bus.gnt0}, (k == 1) ? 8'd0 : 8'd1);
      chk($sformatf("cont%0d_gnt1", k), {7'd0, bus.gnt1}, (k == 1) ? 8'd1 : 8'd0);
      tick();
      chk($sformatf("cont%0d_exec_nogrant", k), {7'd0, bus.gnt0 | bus.gnt1}, 8'd0);
      tick();
      chk($sformatf("cont%0d_valid", k), {7'd0, bus.resp_valid}, 8'd1);
      chk($sformatf("cont%0d_id", k), {7'd0, bus.resp_id}, (k == 1) ? 8'd1 : 8'd0);
      chk($sformatf("cont%0d_data", k), {4'd0, bus.resp_data}, (k == 1) ? 8'd2 : 8'd1);
      tick();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    #1;

    // Overflow: 9 + 8 = 17.
    bus.acc_a = 4'd9;
    bus.op1 = 4'd8;
    bus.req1 = 1'b1;
    #1;
    chk("ovf_gnt1", {7'd0, bus.gnt1}, 8'd1);
    tick();
    bus.req1 = 1'b0;
    tick();
    chk("ovf_valid", {7'd0, bus.resp_valid}, 8'd1);
    chk("ovf_id", {7'd0, bus.resp_id}, 8'd1);
    chk("ovf_carry", {7'd0, bus.resp_carry}, 8'd1);
    chk("ovf_data", {4'd0, bus.resp_data}, {4'd0, OVF_DATA});
    tick();

    // Backpressure: 1 + 6 = 7 held while a second req0 pends.
    bus.resp_ready = 1'b0;
    bus.acc_a = 4'd1;
    bus.op0 = 4'd6;
    bus.req0 = 1'b1;
    #1;
    chk("bp_gnt0", {7'd0, bus.gnt0}, 8'd1);
    tick();
    bus.op0 = 4'd3;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), {7'd0, bus.resp_valid}, 8'd1);
      chk($sformatf("bp%0d_data", k), {4'd0, bus.resp_data}, 8'd7);
      chk($sformatf("bp%0d_id", k), {7'd0, bus.resp_id}, 8'd0);
      chk($sformatf("bp%0d_nogrant", k), {7'd0, bus.gnt0 | bus.gnt1}, 8'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_release_valid", {7'd0, bus.resp_valid}, 8'd0);
    chk("bp_pending_gnt0", {7'd0, bus.gnt0}, 8'd1);
    tick();
    bus.req0 = 1'b0;
    tick();
    chk("bp_second_data", {4'd0, bus.resp_data}, 8'd4);
    chk("bp_second_id", {7'd0, bus.resp_id}, 8'd0);
    tick();

    // Reset during EXEC discards the operation.
    bus.acc_a = 4'd5;
    bus.op0 = 4'd5;
    bus.req0 = 1'b1;
    #1;
    chk("rexec_gnt0", {7'd0, bus.gnt0}, 8'd1);
    tick();
    bus.req0 = 1'b0;
    chk("rexec_busy", {7'd0, bus.busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rexec");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rexec_post%0d_valid", k), {7'd0, bus.resp_valid}, 8'd0);
    end

    // Input change after grant does not affect the result: 2 + 5 = 7.
    bus.acc_a = 4'd2;
    bus.op0 = 4'd5;
    bus.req0 = 1'b1;
    #1;
    chk("late_gnt0", {7'd0, bus.gnt0}, 8'd1);
    tick();
    bus.op0 = 4'd0;
    bus.acc_a = 4'd0;
    bus.req0 = 1'b0;
    tick();
    chk("late_valid", {7'd0, bus.resp_valid}, 8'd1);
    chk("late_data", {4'd0, bus.resp_data}, 8'd7);
    chk("late_carry", {7'd0, bus.resp_carry}, 8'd0);
    tick();
    chk("late_done_valid", {7'd0, bus.resp_valid}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
